// File: rtl/reaction_timer_core.sv
// reaction_timer_core: reaction-time game controller, one round per debounced button press.
//
// A press in IDLE or DONE starts a round. The round waits a pseudo-random number of
// milliseconds, lights the GO LED, and measures whole milliseconds until the next press.
// A press during the wait is a false start. Reaching TIMEOUT_MS in GO is a timeout.
//
// Ports:
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   button_in     in   debounced button level, synchronous to clk
//   led_go        out  high while in GO
//   busy          out  high in WAIT_DELAY or GO
//   result_ms     out  last reaction time in ms, held until the next result
//   result_valid  out  1-cycle pulse when a genuine reaction updates result_ms
//   false_start   out  1-cycle pulse on a press during WAIT_DELAY
//   timeout       out  1-cycle pulse when GO reaches TIMEOUT_MS
//
// Optional build macro REACTION_BEST_TIME_EN adds:
//   best_ms       out  best reaction so far (all ones = no best yet)
//   new_best      out  1-cycle pulse, coincident with result_valid, when best_ms improves
module reaction_timer_core #(
    parameter int TICKS_PER_MS = 100000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11,
    parameter int TIMEOUT_MS   = 9999,
    parameter int TIME_W       = 14
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              button_in,
    output logic              led_go,
    output logic              busy,
    output logic [TIME_W-1:0] result_ms,
    output logic              result_valid,
    output logic              false_start,
    output logic              timeout
`ifdef REACTION_BEST_TIME_EN
    ,
    output logic [TIME_W-1:0] best_ms,
    output logic              new_best
`endif
);

    localparam int TICK_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_DELAY, GO, DONE} state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [TIME_W-1:0]   ms_cnt_q, ms_cnt_d;
    logic [TIME_W-1:0]   delay_q, delay_d;
    logic [TIME_W-1:0]   result_q, result_d;
    logic                btn_prev_q;
    logic                armed_q;
    logic                led_go_q, busy_q;
    logic                result_valid_q, result_valid_d;
    logic                false_start_q, false_start_d;
    logic                timeout_q, timeout_d;

    logic                press;
    logic                tick;
    logic                entry;
    logic [TIME_W-1:0]   ms_inc;
    logic [TIME_W-1:0]   new_delay;

    // armed_q blocks the first cycle after reset so a level held through reset
    // is seen as already-pressed rather than as a fresh edge.
    assign press     = button_in & ~btn_prev_q & armed_q;
    assign tick      = tick_cnt_q == TICK_W'(TICKS_PER_MS - 1);
    assign ms_inc    = ms_cnt_q + TIME_W'(1);
    assign new_delay = TIME_W'(MIN_DELAY_MS) + TIME_W'(lfsr_q[RAND_BITS-1:0]);
    assign entry     = state_d != state_q;

    // Galois form of x^16+x^14+x^13+x^11+1 (shift right, feedback mask 0xB400).
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        state_d        = state_q;
        delay_d        = delay_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        false_start_d  = 1'b0;
        timeout_d      = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (press) begin
                    state_d = WAIT_DELAY;
                    delay_d = new_delay;
                end
            end
            WAIT_DELAY: begin
                if (press) begin
                    state_d       = IDLE;
                    false_start_d = 1'b1;
                end else if (tick && ms_inc == delay_q) begin
                    state_d = GO;
                end
            end
            GO: begin
                if (press) begin
                    state_d        = DONE;
                    result_d       = ms_cnt_q;
                    result_valid_d = 1'b1;
                end else if (tick && ms_inc == TIME_W'(TIMEOUT_MS)) begin
                    state_d   = DONE;
                    result_d  = TIME_W'(TIMEOUT_MS);
                    timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Both counters restart on state entry so the first tick lands exactly
    // TICKS_PER_MS cycles after the entry edge.
    always_comb begin
        tick_cnt_d = (entry || tick) ? '0 : tick_cnt_q + TICK_W'(1);
        ms_cnt_d   = ms_cnt_q;
        if (entry && (state_d == WAIT_DELAY || state_d == GO)) begin
            ms_cnt_d = '0;
        end else if (tick && ms_cnt_q != {TIME_W{1'b1}}) begin
            ms_cnt_d = ms_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            lfsr_q         <= 16'hACE1;
            tick_cnt_q     <= '0;
            ms_cnt_q       <= '0;
            delay_q        <= '0;
            result_q       <= '0;
            btn_prev_q     <= 1'b0;
            armed_q        <= 1'b0;
            led_go_q       <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            tick_cnt_q     <= tick_cnt_d;
            ms_cnt_q       <= ms_cnt_d;
            delay_q        <= delay_d;
            result_q       <= result_d;
            btn_prev_q     <= button_in;
            armed_q        <= 1'b1;
            led_go_q       <= state_d == GO;
            busy_q         <= state_d == WAIT_DELAY || state_d == GO;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
            timeout_q      <= timeout_d;
        end
    end

    assign led_go       = led_go_q;
    assign busy         = busy_q;
    assign result_ms    = result_q;
    assign result_valid = result_valid_q;
    assign false_start  = false_start_q;
    assign timeout      = timeout_q;

`ifdef REACTION_BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;
    logic              new_best_q, new_best_d;

    always_comb begin
        best_d     = best_q;
        new_best_d = 1'b0;
        if (result_valid_d && result_d < best_q) begin
            best_d     = result_d;
            new_best_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_q     <= {TIME_W{1'b1}};
            new_best_q <= 1'b0;
        end else begin
            best_q     <= best_d;
            new_best_q <= new_best_d;
        end
    end

    assign best_ms  = best_q;
    assign new_best = new_best_q;
`endif

endmodule
